// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RISC-V datapath: sequences PC/IR/memory/register writes and steers datapath muxes.
// Optional define MULTICYCLE_BRANCH_EXT_EN adds bne/blt/bge on top of beq.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       neg,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_LUI      = 4'd11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       branch_supported;
    logic       branch_taken;
    logic       decode_illegal;
    logic [2:0] alu_funct;
    logic       pc_update;
    logic       branch_en;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;

    // Which branch flavours exist, and whether the current one is taken.
    always_comb begin
        branch_supported = 1'b0;
        branch_taken     = 1'b0;
`ifdef MULTICYCLE_BRANCH_EXT_EN
        case (funct3)
            3'b000: begin branch_supported = 1'b1; branch_taken = zero;  end
            3'b001: begin branch_supported = 1'b1; branch_taken = !zero; end
            3'b100: begin branch_supported = 1'b1; branch_taken = neg;   end
            3'b101: begin branch_supported = 1'b1; branch_taken = !neg;  end
            default: begin branch_supported = 1'b0; branch_taken = 1'b0; end
        endcase
`else
        if (funct3 == 3'b000) begin
            branch_supported = 1'b1;
            branch_taken     = zero;
        end
`endif
    end

    always_comb begin
        case (funct3)
            3'b000:  alu_funct = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_funct = ALU_SLT;
            3'b110:  alu_funct = ALU_OR;
            3'b111:  alu_funct = ALU_AND;
            default: alu_funct = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d        = S_FETCH;
        decode_illegal = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    OP_BRANCH: begin
                        state_d        = branch_supported ? S_BRANCH : S_FETCH;
                        decode_illegal = !branch_supported;
                    end
                    default: begin
                        state_d        = S_FETCH;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore decode of datapath controls; write enables are gated by reset below.
    always_comb begin
        pc_update     = 1'b0;
        branch_en     = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUControl    = ALU_ADD;
        ImmSrc        = IMM_I;
        case (state_q)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                pc_update    = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = IMM_B;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_funct;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_funct;
            end
            S_ALUWB: reg_write_raw = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                branch_en  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ImmSrc    = IMM_J;
                pc_update = 1'b1;
            end
            S_LUI: begin
                ImmSrc        = IMM_U;
                ResultSrc     = 2'b11;
                reg_write_raw = 1'b1;
            end
            default: begin
                pc_update = 1'b0;
            end
        endcase
    end

    assign PCWrite  = rst & (pc_update | (branch_en & branch_taken));
    assign MemWrite = rst & mem_write_raw;
    assign IRWrite  = rst & ir_write_raw;
    assign RegWrite = rst & reg_write_raw;
    assign illegal  = rst & (state_q == S_DECODE) & decode_illegal;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed then random instructions against a per-instruction path model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       neg;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl, ImmSrc;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        logic       n;
    } instr_t;

    int path[5];
    int path_len;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .neg(neg), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic br_ok(input logic [2:0] f3);
`ifdef MULTICYCLE_BRANCH_EXT_EN
        return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd5);
`else
        return f3 == 3'd0;
`endif
    endfunction

    function automatic logic br_taken(input instr_t in);
        case (in.f3)
            3'd0:    return in.z;
            3'd1:    return !in.z;
            3'd4:    return in.n;
            3'd5:    return !in.n;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input instr_t in);
        case (in.f3)
            3'b000:  return (in.op == 7'b0110011 && in.f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Sequence of states an instruction visits, starting at its FETCH.
    task automatic build_path(input instr_t in);
        path[0] = 0;
        path[1] = 1;
        path_len = 2;
        case (in.op)
            7'b0000011: begin path[2] = 2; path[3] = 3; path[4] = 4; path_len = 5; end
            7'b0100011: begin path[2] = 2; path[3] = 5; path_len = 4; end
            7'b0110011: begin path[2] = 6; path[3] = 8; path_len = 4; end
            7'b0010011: begin path[2] = 7; path[3] = 8; path_len = 4; end
            7'b1101111: begin path[2] = 10; path[3] = 8; path_len = 4; end
            7'b0110111: begin path[2] = 11; path_len = 3; end
            7'b1100011: if (br_ok(in.f3)) begin path[2] = 9; path_len = 3; end
            default: path_len = 2;
        endcase
    endtask

    // Expected {PCWrite,MemWrite,IRWrite,RegWrite,illegal} and {AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc}.
    task automatic expect_ctrl(input int st, input instr_t in, output logic [4:0] en, output logic [12:0] sel);
        logic pcw, memw, irw, regw, ill, adr;
        logic [1:0] rs, sa, sb;
        logic [2:0] ac, im;
        {pcw, memw, irw, regw, ill, adr} = '0;
        {rs, sa, sb, ac, im} = '0;
        case (st)
            0:  begin pcw = 1; irw = 1; sb = 2; rs = 2; end
            1:  begin sa = 1; sb = 1; im = 2; ill = (path_len == 2); end
            2:  begin sa = 2; sb = 1; im = (in.op == 7'b0100011) ? 3'd1 : 3'd0; end
            3:  adr = 1;
            4:  begin rs = 1; regw = 1; end
            5:  begin adr = 1; memw = 1; end
            6:  begin sa = 2; ac = alu_of(in); end
            7:  begin sa = 2; sb = 1; ac = alu_of(in); end
            8:  regw = 1;
            9:  begin sa = 2; ac = 3'b001; pcw = br_taken(in); end
            10: begin sa = 1; sb = 2; im = 3; pcw = 1; end
            11: begin im = 4; rs = 3; regw = 1; end
            default: ;
        endcase
        en  = {pcw, memw, irw, regw, ill};
        sel = {adr, rs, sa, sb, ac, im};
    endtask

    task automatic run_instr(input instr_t in, input string name);
        logic [4:0]  en;
        logic [12:0] sel;
        op = in.op; funct3 = in.f3; funct7b5 = in.f7; zero = in.z; neg = in.n;
        #1;
        build_path(in);
        for (int k = 0; k < path_len; k++) begin
            expect_ctrl(path[k], in, en, sel);
            check({name, " state"}, 32'(state), 32'(path[k]));
            check({name, " enables"}, 32'({PCWrite, MemWrite, IRWrite, RegWrite, illegal}), 32'(en));
            check({name, " selects"}, 32'({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc}), 32'(sel));
            step();
        end
        check({name, " back_to_fetch"}, 32'(state), 32'd0);
        $display("instr %-8s op=%b f3=%b f7=%b z=%b n=%b cycles=%0d", name, in.op, in.f3, in.f7, in.z, in.n, path_len);
    endtask

    function automatic instr_t mk(input logic [6:0] o, input logic [2:0] f, input logic f7, input logic z, input logic n);
        instr_t r;
        r.op = o; r.f3 = f; r.f7 = f7; r.z = z; r.n = n;
        return r;
    endfunction

    logic [6:0] op_pool [9];
    instr_t     ri;

    initial begin
        rst = 1'b0; op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; neg = 1'b0;
        step();
        step();
        check("reset state", 32'(state), 32'd0);
        check("reset enables", 32'({PCWrite, MemWrite, IRWrite, RegWrite, illegal}), 32'd0);
        rst = 1'b1;
        #1;

        run_instr(mk(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0), "lw");
        run_instr(mk(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0), "sw");
        run_instr(mk(7'b0110011, 3'd0, 1'b1, 1'b0, 1'b0), "sub");
        run_instr(mk(7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0), "add");
        run_instr(mk(7'b0010011, 3'd0, 1'b1, 1'b0, 1'b0), "addi_f7");
        run_instr(mk(7'b0110011, 3'd2, 1'b0, 1'b0, 1'b0), "slt");
        run_instr(mk(7'b0110011, 3'd6, 1'b0, 1'b0, 1'b0), "or");
        run_instr(mk(7'b0010011, 3'd7, 1'b0, 1'b0, 1'b0), "andi");
        run_instr(mk(7'b1100011, 3'd0, 1'b0, 1'b1, 1'b0), "beq_t");
        run_instr(mk(7'b1100011, 3'd0, 1'b0, 1'b0, 1'b0), "beq_nt");
        run_instr(mk(7'b1100011, 3'd1, 1'b0, 1'b0, 1'b0), "bne");
        run_instr(mk(7'b1100011, 3'd5, 1'b0, 1'b0, 1'b1), "bge_neg");
        run_instr(mk(7'b1110011, 3'd0, 1'b0, 1'b0, 1'b0), "ecall");
        run_instr(mk(7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0), "jal");
        run_instr(mk(7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0), "lui");

        // Reset in ALUWB of an R-type: abandons the instruction, no writes.
        op = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0;
        step(); step(); step();
        check("pre-reset aluwb", 32'(state), 32'd8);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("midreset writes", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'd0);
            step();
            check("midreset state", 32'(state), 32'd0);
        end
        check("midreset writes", 32'({PCWrite, MemWrite, RegWrite, IRWrite}), 32'd0);
        rst = 1'b1;
        #1;
        $display("reset mid-instruction done state=%0d", state);

        op_pool = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                    7'b1101111, 7'b0110111, 7'b1110011, 7'b0000000};
        for (int i = 0; i < 150; i++) begin
            ri.op = op_pool[$urandom_range(0, 8)];
            if (ri.op == 7'b0000000) ri.op = 7'($urandom);
            ri.f3 = 3'($urandom);
            ri.f7 = 1'($urandom);
            ri.z  = 1'($urandom);
            ri.n  = 1'($urandom);
            run_instr(ri, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
